amm2ahb: RTL and testbench
==========================

Name: amm2ahb

Overview:
- Avalon-MM slave to AHB-Lite master bridge; the opposite direction of the team's AHB-to-AMM bridge.
- Lets an Avalon-MM master, such as a DMA or soft CPU data port, reach AHB-Lite peripherals.
- Issues one AHB SINGLE transfer per Avalon access, or a short sequence of byte transfers for sparse byteenables when the optional feature is compiled in.
- Holds amm_waitrequest high until the AHB data phase completes.

Parameters:
- P_HPROT, 4'b0011, constant value driven on ahb_hprot (non-cacheable, non-bufferable, privileged, data).

Ports:
- aclk  input  1  single clock for both interfaces
- areset  input  1  reset; asynchronous and active-high
- amm_address  input  32  byte address from the Avalon master
- amm_writedata  input  32  write data
- amm_byteenable  input  4  byte lane enables
- amm_write  input  1  write request
- amm_read  input  1  read request
- amm_readdata  output  32  read data; valid in the cycle amm_waitrequest is low for a read
- amm_response  output  2  2'b00 OKAY, 2'b10 SLAVEERROR; valid with amm_waitrequest low
- amm_waitrequest  output  1  high stalls the Avalon master
- ahb_haddr  output  32  AHB address
- ahb_htrans  output  2  AHB transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are used
- ahb_hwrite  output  1  AHB write strobe
- ahb_hsize  output  3  AHB transfer size
- ahb_hburst  output  3  constant 3'b000 (SINGLE)
- ahb_hprot  output  4  constant P_HPROT
- ahb_hwdata  output  32  AHB write data
- ahb_hrdata  input  32  AHB read data
- ahb_hready  input  1  AHB ready
- ahb_hresp  input  1  AHB error response

Behaviour:
- All outputs are registered.
- Reset values:
  - amm_waitrequest=1
  - amm_readdata=0, amm_response=0
  - ahb_htrans=IDLE, ahb_haddr=0, ahb_hwrite=0, ahb_hsize=0, ahb_hwdata=0
- Reset asserted mid-transfer: returns to IDLE immediately and forces ahb_htrans=IDLE. The Avalon access is lost.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - amm_read or amm_write seen: latch address, data, byteenable and direction, then go to ADDR.
  - If amm_read and amm_write are both high, the write wins.
- ADDR:
  - Drive htrans=NONSEQ with haddr, hsize and hwrite.
  - On hready=1, go to DATA; htrans=IDLE in the next cycle.
- DATA:
  - Drive hwdata for writes.
  - On hready=1 with hresp=0: capture hrdata for reads, then go to DONE, or back to ADDR if split beats remain.
- DONE:
  - amm_waitrequest=0 for exactly 1 cycle, then IDLE.
  - amm_waitrequest is 1 in every other state.
- Minimum latency with a zero-wait AHB slave: request in cycle 0, waitrequest low in cycle 3.
- Byteenable to AHB mapping (haddr[31:2]=amm_address[31:2]):
  - 4'b1111 -> word, haddr[1:0]=0
  - 4'b0011 -> halfword, offset 0
  - 4'b1100 -> halfword, offset 2
  - single bit n -> byte, offset n
  - other non-zero patterns -> sparse (see Optional Feature)
- Reads: always a word access with haddr[1:0]=0; byteenable is ignored.
- Write with byteenable=0: no AHB transfer; goes straight to DONE with OKAY.
- Error (hresp=1):
  - First error cycle (hready=0): keep htrans=IDLE.
  - Second error cycle (hready=1): latch amm_response=2'b10 and abort any remaining split beats.
  - Go to DONE; readdata for an errored read is 0.
- Two back-to-back requests: the second is sampled in IDLE the cycle after DONE. There are no overlapping AHB pipeline stages.

Optional Feature:
- Macro: AMM2AHB_SPLIT_EN.
- Defined: a sparse write (e.g. 4'b0101, 4'b1110) becomes one byte NONSEQ transfer per set bit, issued in ascending lane order, each a full ADDR/DATA pair. The response is OKAY unless any beat errors.
- Undefined: a sparse write issues no AHB transfer and completes via DONE with amm_response=2'b10.

Test Plan:
- Word write 0x4000_0010 with data 0xDEADBEEF, be=4'hF, hready tied 1 -> one NONSEQ, hsize=2, haddr=0x4000_0010, hwdata=0xDEADBEEF; waitrequest low in cycle 3; response 00.
- Read 0x4000_0020, slave returns 0x1234_5678 with 2 wait states in the data phase -> readdata=0x12345678; waitrequest low in cycle 5.
- Write be=4'b1100 at 0x100 -> hsize=1, haddr=0x102. Write be=4'b0100 -> hsize=0, haddr=0x102.
- Write be=4'b0101 at 0x200:
  - With AMM2AHB_SPLIT_EN -> two byte beats, haddr 0x200 then 0x202; response 00.
  - Without it -> no NONSEQ; response 2'b10.
- Read with a two-cycle AHB error response -> amm_response=2'b10, readdata=0; next request accepted normally.
- areset pulsed during the DATA phase -> htrans=IDLE and waitrequest=1 asynchronously; the following write completes correctly.

Source files
------------

// File: rtl/amm2ahb.sv
// amm2ahb: Avalon-MM slave to AHB-Lite master bridge.
// Each Avalon access becomes one AHB SINGLE transfer (no pipelining between
// transfers). amm_waitrequest stays high until the AHB data phase completes,
// then drops for exactly one cycle together with readdata/response.
// Build option: define AMM2AHB_SPLIT_EN to turn sparse-byteenable writes into
// one byte transfer per enabled lane; without it such writes are rejected
// with SLAVEERROR and no AHB transfer.
module amm2ahb #(
   parameter logic [3:0] P_HPROT = 4'b0011
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] amm_address,
   input  logic [31:0] amm_writedata,
   input  logic [3:0]  amm_byteenable,
   input  logic        amm_write,
   input  logic        amm_read,
   output logic [31:0] amm_readdata,
   output logic [1:0]  amm_response,
   output logic        amm_waitrequest,
   output logic [31:0] ahb_haddr,
   output logic [1:0]  ahb_htrans,
   output logic        ahb_hwrite,
   output logic [2:0]  ahb_hsize,
   output logic [2:0]  ahb_hburst,
   output logic [3:0]  ahb_hprot,
   output logic [31:0] ahb_hwdata,
   input  logic [31:0] ahb_hrdata,
   input  logic        ahb_hready,
   input  logic        ahb_hresp
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [2:0] HSIZE_BYTE    = 3'd0;
   localparam logic [2:0] HSIZE_HALF    = 3'd1;
   localparam logic [2:0] HSIZE_WORD    = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      BE_NONE,
      BE_NATURAL,
      BE_SPARSE
   } be_kind_t;

   state_t      state;
   logic [31:0] wdata_q;

   be_kind_t    be_kind;
   logic [2:0]  be_size;
   logic [1:0]  be_off;

   // Address lsbs are derived from the byte enables, not from the master.
   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^amm_address[1:0];

   assign ahb_hburst = 3'b000;
   assign ahb_hprot  = P_HPROT;

`ifdef AMM2AHB_SPLIT_EN
   // Lanes still to be issued after the beat currently in flight.
   logic [3:0] lanes_left;
   logic [1:0] first_lane;
   logic [1:0] next_lane;

   function automatic logic [1:0] lowest_lane(input logic [3:0] m);
      logic [1:0] l;
      casez (m)
         4'b???1: l = 2'd0;
         4'b??10: l = 2'd1;
         4'b?100: l = 2'd2;
         default: l = 2'd3;
      endcase
      return l;
   endfunction

   assign first_lane = lowest_lane(amm_byteenable);
   assign next_lane  = lowest_lane(lanes_left);
`endif

   // Classify the byte enables into an AHB size/offset for a single transfer.
   always_comb begin
      be_kind = BE_SPARSE;
      be_size = HSIZE_BYTE;
      be_off  = 2'd0;
      case (amm_byteenable)
         4'b0000: be_kind = BE_NONE;
         4'b1111: begin be_kind = BE_NATURAL; be_size = HSIZE_WORD; be_off = 2'd0; end
         4'b0011: begin be_kind = BE_NATURAL; be_size = HSIZE_HALF; be_off = 2'd0; end
         4'b1100: begin be_kind = BE_NATURAL; be_size = HSIZE_HALF; be_off = 2'd2; end
         4'b0001: begin be_kind = BE_NATURAL; be_size = HSIZE_BYTE; be_off = 2'd0; end
         4'b0010: begin be_kind = BE_NATURAL; be_size = HSIZE_BYTE; be_off = 2'd1; end
         4'b0100: begin be_kind = BE_NATURAL; be_size = HSIZE_BYTE; be_off = 2'd2; end
         4'b1000: begin be_kind = BE_NATURAL; be_size = HSIZE_BYTE; be_off = 2'd3; end
         default: ;
      endcase
   end

   // Bridge FSM: accept Avalon access, run AHB address/data phases, report.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state           <= ST_IDLE;
         wdata_q         <= '0;
         amm_readdata    <= '0;
         amm_response    <= RESP_OKAY;
         amm_waitrequest <= 1'b1;
         ahb_haddr       <= '0;
         ahb_htrans      <= HTRANS_IDLE;
         ahb_hwrite      <= 1'b0;
         ahb_hsize       <= '0;
         ahb_hwdata      <= '0;
`ifdef AMM2AHB_SPLIT_EN
         lanes_left      <= '0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (amm_write) begin
                  ahb_hwrite   <= 1'b1;
                  wdata_q      <= amm_writedata;
                  amm_response <= RESP_OKAY;
                  case (be_kind)
                     BE_NONE: begin
                        amm_waitrequest <= 1'b0;
                        state           <= ST_DONE;
                     end
                     BE_NATURAL: begin
                        ahb_haddr  <= {amm_address[31:2], be_off};
                        ahb_hsize  <= be_size;
                        ahb_htrans <= HTRANS_NONSEQ;
                        state      <= ST_ADDR;
`ifdef AMM2AHB_SPLIT_EN
                        lanes_left <= '0;
`endif
                     end
                     default: begin
`ifdef AMM2AHB_SPLIT_EN
                        ahb_haddr  <= {amm_address[31:2], first_lane};
                        ahb_hsize  <= HSIZE_BYTE;
                        ahb_htrans <= HTRANS_NONSEQ;
                        lanes_left <= amm_byteenable & ~(4'b0001 << first_lane);
                        state      <= ST_ADDR;
`else
                        amm_response    <= RESP_SLVERR;
                        amm_waitrequest <= 1'b0;
                        state           <= ST_DONE;
`endif
                     end
                  endcase
               end else if (amm_read) begin
                  ahb_hwrite   <= 1'b0;
                  amm_response <= RESP_OKAY;
                  ahb_haddr    <= {amm_address[31:2], 2'b00};
                  ahb_hsize    <= HSIZE_WORD;
                  ahb_htrans   <= HTRANS_NONSEQ;
                  state        <= ST_ADDR;
`ifdef AMM2AHB_SPLIT_EN
                  lanes_left   <= '0;
`endif
               end
            end

            ST_ADDR: begin
               if (ahb_hready) begin
                  ahb_htrans <= HTRANS_IDLE;
                  if (ahb_hwrite) begin
                     ahb_hwdata <= wdata_q;
                  end
                  state <= ST_DATA;
               end
            end

            ST_DATA: begin
               // hresp with hready low is the first error cycle: htrans is
               // already IDLE, so simply wait for the second cycle.
               if (ahb_hready) begin
                  if (ahb_hresp) begin
                     amm_response <= RESP_SLVERR;
                     if (!ahb_hwrite) begin
                        amm_readdata <= '0;
                     end
`ifdef AMM2AHB_SPLIT_EN
                     lanes_left <= '0;
`endif
                     amm_waitrequest <= 1'b0;
                     state           <= ST_DONE;
                  end else begin
                     if (!ahb_hwrite) begin
                        amm_readdata <= ahb_hrdata;
                     end
`ifdef AMM2AHB_SPLIT_EN
                     if (lanes_left != '0) begin
                        ahb_haddr[1:0] <= next_lane;
                        lanes_left     <= lanes_left & ~(4'b0001 << next_lane);
                        ahb_htrans     <= HTRANS_NONSEQ;
                        state          <= ST_ADDR;
                     end else begin
                        amm_waitrequest <= 1'b0;
                        state           <= ST_DONE;
                     end
`else
                     amm_waitrequest <= 1'b0;
                     state           <= ST_DONE;
`endif
                  end
               end
            end

            ST_DONE: begin
               amm_waitrequest <= 1'b1;
               state           <= ST_IDLE;
            end

            default: begin
               amm_waitrequest <= 1'b1;
               ahb_htrans      <= HTRANS_IDLE;
               state           <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_amm2ahb.sv
// tb_amm2ahb: scoreboard bench for amm2ahb. A reference model turns each
// Avalon request into expected AHB beats and an expected completion; an AHB
// slave/monitor process and an Avalon completion monitor pop and compare.
`timescale 1ns/1ps
module tb_amm2ahb;
`ifdef AMM2AHB_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] amm_address = '0;
   logic [31:0] amm_writedata = '0;
   logic [3:0]  amm_byteenable = '0;
   logic        amm_write = 1'b0;
   logic        amm_read = 1'b0;
   logic [31:0] amm_readdata;
   logic [1:0]  amm_response;
   logic        amm_waitrequest;
   logic [31:0] ahb_haddr;
   logic [1:0]  ahb_htrans;
   logic        ahb_hwrite;
   logic [2:0]  ahb_hsize;
   logic [2:0]  ahb_hburst;
   logic [3:0]  ahb_hprot;
   logic [31:0] ahb_hwdata;
   logic [31:0] ahb_hrdata = '0;
   logic        ahb_hready = 1'b1;
   logic        ahb_hresp = 1'b0;

   amm2ahb #(.P_HPROT(4'b0011)) dut (
      .aclk(aclk), .areset(areset),
      .amm_address(amm_address), .amm_writedata(amm_writedata),
      .amm_byteenable(amm_byteenable), .amm_write(amm_write), .amm_read(amm_read),
      .amm_readdata(amm_readdata), .amm_response(amm_response),
      .amm_waitrequest(amm_waitrequest),
      .ahb_haddr(ahb_haddr), .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
      .ahb_hsize(ahb_hsize), .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot),
      .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata), .ahb_hready(ahb_hready),
      .ahb_hresp(ahb_hresp)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      bit          write;
      logic [31:0] wdata;
      int unsigned waits;
      bit          err;
      logic [31:0] rdata;
   } beat_t;

   typedef struct {
      bit          write;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int unsigned lat;
      int unsigned t0;
   } cpl_t;

   beat_t beat_q[$];
   cpl_t  cpl_q[$];

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   int unsigned cyc = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   endtask

   // Reference model: from the request and the slave plan, list the AHB beats
   // that must appear and the completion the master must see.
   task automatic expect_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int unsigned waits, input bit err,
                             input logic [31:0] rdata, input int unsigned t0);
      cpl_t  c;
      beat_t b;
      int    cnt, lo, run;
      bit    natural;
      c.write = wr; c.t0 = t0; c.rdata = '0; c.resp = 2'b00; c.lat = 1;
      b.write = wr; b.wdata = wdata; b.waits = waits; b.err = err; b.rdata = rdata;
      if (!wr) begin
         b.addr = {addr[31:2], 2'b00};
         b.size = 3'd2;
         beat_q.push_back(b);
         c.lat   = 3 + waits + (err ? 1 : 0);
         c.resp  = err ? 2'b10 : 2'b00;
         c.rdata = err ? 32'h0 : rdata;
      end else if (be != 4'b0000) begin
         cnt = 0; lo = -1;
         for (int i = 0; i < 4; i++) if (be[i]) begin cnt++; if (lo < 0) lo = i; end
         run = ((1 << cnt) - 1) << lo;
         natural = (run == int'(be)) && (cnt == 1 || cnt == 4 || (cnt == 2 && lo % 2 == 0));
         if (natural) begin
            b.addr = {addr[31:2], 2'(lo)};
            b.size = (cnt == 4) ? 3'd2 : (cnt == 2) ? 3'd1 : 3'd0;
            beat_q.push_back(b);
            c.lat  = 3 + waits + (err ? 1 : 0);
            c.resp = err ? 2'b10 : 2'b00;
         end else if (SPLIT) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i] && c.resp == 2'b00) begin
                  b.addr = {addr[31:2], 2'(i)};
                  b.size = 3'd0;
                  b.err  = err && (c.lat == 1);
                  beat_q.push_back(b);
                  c.lat += 2 + waits + (b.err ? 1 : 0);
                  if (b.err) c.resp = 2'b10;
               end
            end
         end else begin
            c.resp = 2'b10;
         end
      end
      cpl_q.push_back(c);
   endtask

   // AHB slave model and address-phase monitor.
   bit          dp_act = 1'b0;
   bit          dp_errflag = 1'b0;
   bit          nxt_act;
   beat_t       dp;
   beat_t       ab;
   int unsigned dp_wait = 0;
   logic [31:0] lane_mask;

   always @(negedge aclk) begin
      if (areset) begin
         ahb_hready = 1'b1;
         ahb_hresp  = 1'b0;
         dp_act     = 1'b0;
      end else begin
         nxt_act = 1'b0;
         if (dp_act) begin
            if (dp_wait > 0) begin
               ahb_hready = 1'b0; ahb_hresp = 1'b0; ahb_hrdata = $urandom;
               dp_wait--;
               nxt_act = 1'b1;
            end else if (dp.err && !dp_errflag) begin
               ahb_hready = 1'b0; ahb_hresp = 1'b1; ahb_hrdata = $urandom;
               dp_errflag = 1'b1;
               nxt_act = 1'b1;
            end else begin
               ahb_hready = 1'b1;
               ahb_hresp  = dp.err;
               ahb_hrdata = dp.err ? $urandom : dp.rdata;
               if (dp.write) begin
                  lane_mask = (dp.size == 3'd2) ? 32'hFFFF_FFFF :
                              (dp.size == 3'd1) ? (32'h0000_FFFF << (8 * dp.addr[1:0])) :
                                                  (32'h0000_00FF << (8 * dp.addr[1:0]));
                  check("hwdata", ahb_hwdata & lane_mask, dp.wdata & lane_mask);
               end
            end
         end else begin
            ahb_hready = 1'b1; ahb_hresp = 1'b0; ahb_hrdata = $urandom;
         end
         if (ahb_htrans == 2'b10) begin
            if (ahb_hready) begin
               if (beat_q.size() == 0) begin
                  check("unexpected_nonseq", 1, 0);
               end else begin
                  ab = beat_q.pop_front();
                  check("haddr", ahb_haddr, ab.addr);
                  check("hsize", ahb_hsize, ab.size);
                  check("hwrite", ahb_hwrite, ab.write);
                  check("hburst", ahb_hburst, 3'b000);
                  check("hprot", ahb_hprot, 4'b0011);
                  dp = ab; dp_wait = ab.waits; dp_errflag = 1'b0;
                  nxt_act = 1'b1;
               end
            end
         end else begin
            check("htrans_idle", ahb_htrans, 2'b00);
         end
         dp_act = nxt_act;
      end
   end

   // Avalon completion monitor.
   cpl_t ec;
   always @(negedge aclk) begin
      if (!areset && amm_waitrequest === 1'b0) begin
         if (cpl_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            ec = cpl_q.pop_front();
            check("response", amm_response, ec.resp);
            if (!ec.write) check("readdata", amm_readdata, ec.rdata);
            check("latency", cyc - ec.t0, ec.lat);
            check("beats_left", beat_q.size(), 0);
         end
      end
   end

   task automatic run_txn(input bit wr, input bit rd_also, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int unsigned waits, input bit err, input logic [31:0] rdata);
      int unsigned k;
      amm_address = addr; amm_writedata = wdata; amm_byteenable = be;
      amm_write = wr; amm_read = !wr || rd_also;
      expect_txn(wr, addr, wdata, be, waits, err, rdata, cyc);
      k = 0;
      do begin @(negedge aclk); k++; end while (amm_waitrequest !== 1'b0 && k < 200);
      if (amm_waitrequest !== 1'b0) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout: waitrequest stayed %b after %0d cycles, required 0", amm_waitrequest, k);
         finish_run();
      end
      @(negedge aclk);
      amm_write = 1'b0; amm_read = 1'b0;
   endtask

   logic [3:0]  be_tab [8] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
   logic [3:0]  rbe;
   bit          rwr;
   beat_t       rb;
   int unsigned k;

   initial begin
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      check("rst_waitreq", amm_waitrequest, 1'b1);
      check("rst_readdata", amm_readdata, 32'h0);
      check("rst_response", amm_response, 2'b00);
      check("rst_htrans", ahb_htrans, 2'b00);
      check("rst_haddr", ahb_haddr, 32'h0);
      check("rst_hwrite", ahb_hwrite, 1'b0);
      check("rst_hsize", ahb_hsize, 3'd0);
      check("rst_hwdata", ahb_hwdata, 32'h0);
      areset = 1'b0;
      @(negedge aclk);

      run_txn(1, 0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0);
      run_txn(0, 0, 32'h4000_0020, 32'h0, 4'hF, 2, 0, 32'h1234_5678);
      run_txn(1, 0, 32'h0000_0100, 32'hA5A5_5A5A, 4'b1100, 0, 0, 32'h0);
      run_txn(1, 0, 32'h0000_0100, 32'h0077_0000, 4'b0100, 1, 0, 32'h0);
      run_txn(1, 0, 32'h0000_0200, 32'h0011_0022, 4'b0101, 0, 0, 32'h0);
      run_txn(1, 0, 32'h0000_0300, 32'hCAFE_F00D, 4'b1110, 1, 0, 32'h0);
      run_txn(0, 0, 32'h4000_0044, 32'h0, 4'h0, 0, 1, 32'h9999_9999);
      run_txn(0, 0, 32'h4000_0048, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D);
      run_txn(1, 0, 32'h0000_0400, 32'h1111_1111, 4'b0000, 0, 0, 32'h0);
      run_txn(1, 1, 32'h0000_0500, 32'h2222_3333, 4'b0011, 0, 1, 32'h0);

      // Reset pulse while a read sits in its data phase.
      amm_address = 32'h5000_0040; amm_byteenable = 4'hF; amm_write = 1'b0; amm_read = 1'b1;
      rb.addr = 32'h5000_0040; rb.size = 3'd2; rb.write = 1'b0; rb.wdata = '0;
      rb.waits = 6; rb.err = 1'b0; rb.rdata = 32'h7777_7777;
      beat_q.push_back(rb);
      k = 0;
      while (!dp_act && k < 50) begin @(negedge aclk); k++; end
      if (!dp_act) begin
         n_cmp++; n_fail++;
         $display("FAIL reset_setup: data phase not reached after %0d cycles, required 1", k);
         finish_run();
      end
      @(posedge aclk);
      #2;
      areset = 1'b1;
      #1;
      check("rst_mid_htrans", ahb_htrans, 2'b00);
      check("rst_mid_waitreq", amm_waitrequest, 1'b1);
      check("rst_mid_haddr", ahb_haddr, 32'h0);
      amm_read = 1'b0;
      beat_q.delete();
      cpl_q.delete();
      @(negedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      run_txn(1, 0, 32'h6000_0008, 32'h0BEE_F00D, 4'hF, 0, 0, 32'h0);

      for (int unsigned n = 0; n < 300; n++) begin
         rwr = ($urandom_range(0, 2) != 0);
         rbe = ($urandom_range(0, 1) == 1) ? be_tab[$urandom_range(0, 7)] : 4'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge aclk);
         run_txn(rwr, ($urandom_range(0, 3) == 0), $urandom, $urandom, rbe,
                 $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom);
      end

      repeat (3) @(negedge aclk);
      check("final_cpl_q", cpl_q.size(), 0);
      check("final_beat_q", beat_q.size(), 0);
      finish_run();
   end

endmodule
